// File: rtl/gate_pkg.sv
// Shared types and the reference gate function for the gate self-check sequencer.
package gate_pkg;

  typedef enum logic [1:0] {GATE_AND, GATE_OR, GATE_XOR, GATE_NAND} gate_op_t;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} gts_state_t;

  // Only the low n bits of v are meaningful; higher bits are ignored.
  function automatic logic gate_ref(gate_op_t op, logic [7:0] v, int n);
    logic a;
    logic o;
    logic x;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        a = a & v[i];
        o = o | v[i];
        x = x ^ v[i];
      end
    end
    case (op)
      GATE_AND:  gate_ref = a;
      GATE_OR:   gate_ref = o;
      GATE_XOR:  gate_ref = x;
      GATE_NAND: gate_ref = ~a;
      default:   gate_ref = a;
    endcase
  endfunction

endpackage

// File: rtl/gate_test_seq_settle_timer.sv
// Loadable down-counter that holds at zero; zero flags the end of a settle window.
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_test_seq.sv
// Walks a gate's inputs through every vector, samples its output after a settle
// window and reports pass/fail, mismatch count and the first failing vector.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | vector applied, settle timer counting down
// CHECK  | dut_y compared against the reference for one cycle
// DONE   | one-cycle done pulse, pass/err_cnt final
module gate_test_seq
  import gate_pkg::*;
#(
  parameter int       N_IN          = 2,
  parameter int       SETTLE_CYCLES = 4,
  parameter gate_op_t OP            = GATE_AND
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int            TW       = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYCLES - 1);

  gts_state_t      state;
  logic [N_IN-1:0] vec;
  logic            exp_y;
  logic            mism;
  logic            tmr_load;
  logic            tmr_zero;

  assign exp_y    = gate_ref(OP, 8'(vec), N_IN);
  assign tmr_load = ((state == IDLE) && start) || (state == CHECK);
  assign stim     = vec;

  // Written so that an unknown dut_y falls through to a mismatch.
  always_comb begin
    mism = 1'b1;
    if (dut_y == exp_y) mism = 1'b0;
  end

  settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (state == SETTLE),
    .load_val (LOAD_VAL),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETTLE;
            vec     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (tmr_zero) state <= CHECK;
        end
        CHECK: begin
          if (mism) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err_vec <= vec;
          end
          if (vec == '1) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mism;
          end else begin
            vec   <= vec + 1'b1;
            state <= SETTLE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_seq.sv
// Scoreboard bench: runs push expected completion records, monitors pop them on done.
module tb_gate_test_seq;
  import gate_pkg::*;

  typedef struct {
    int cyc;
    int err;
    int first;
    int pass;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       rst_a, start_a, dut_y_a, busy_a, done_a, pass_a;
  logic [1:0] stim_a, first_a;
  logic [2:0] err_a;
  int         mode_a = 0;

  logic       rst_b, start_b, dut_y_b, busy_b, done_b, pass_b;
  logic [2:0] stim_b, first_b;
  logic [3:0] err_b;
  int         mode_b = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  gate_test_seq #(.N_IN(2), .SETTLE_CYCLES(4), .OP(GATE_AND)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stim(stim_a), .dut_y(dut_y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_err_vec(first_a)
  );

  gate_test_seq #(.N_IN(3), .SETTLE_CYCLES(1), .OP(GATE_XOR)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stim(stim_b), .dut_y(dut_y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_err_vec(first_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: 0 good, 1 stuck-at-1, 2 inverted only on vector 11.
  always_comb begin
    case (mode_a)
      1:       dut_y_a = 1'b1;
      2:       dut_y_a = (stim_a == 2'b11) ? 1'b0 : (&stim_a);
      default: dut_y_a = &stim_a;
    endcase
    dut_y_b = (mode_b == 1) ? ~(^stim_b) : (^stim_b);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_a && done_a) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_done_cycle", cyc, e.cyc);
        chk("a_err_cnt", int'(err_a), e.err);
        chk("a_pass", int'(pass_a), e.pass);
        if (e.err != 0) chk("a_first_err_vec", int'(first_a), e.first);
      end
    end
    if (!rst_b && done_b) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_done_cycle", cyc, e.cyc);
        chk("b_err_cnt", int'(err_b), e.err);
        chk("b_pass", int'(pass_b), e.pass);
        if (e.err != 0) chk("b_first_err_vec", int'(first_b), e.first);
      end
    end
    if (busy_a && $isunknown(dut_y_a)) chk("a_x_on_dut_y", 1, 0);
    if (busy_b && $isunknown(dut_y_b)) chk("b_x_on_dut_y", 1, 0);
  end

  // One full run on dut_a; expected done cycle is start cycle + 21.
  task automatic run_a(input int mode, input int e_err, input int e_first, input int e_pass);
    int base;
    mode_a  = mode;
    base    = cyc;
    start_a = 1'b1;
    q_a.push_back('{base + 21, e_err, e_first, e_pass});
    for (int r = 1; r <= 22; r++) begin
      wait_to(base + r);
      start_a = 1'b0;
      if (r <= 20) chk("a_stim", int'(stim_a), (r - 1) / 5);
      chk("a_busy", int'(busy_a), (r <= 21) ? 1 : 0);
    end
    wait_to(base + 24);
    chk("a_pass_held", int'(pass_a), e_pass);
    chk("a_err_held", int'(err_a), e_err);
  endtask

  task automatic run_b(input int mode, input int e_err, input int e_pass);
    int base;
    mode_b  = mode;
    base    = cyc;
    start_b = 1'b1;
    q_b.push_back('{base + 17, e_err, 0, e_pass});
    for (int r = 1; r <= 18; r++) begin
      wait_to(base + r);
      start_b = 1'b0;
      if (r <= 16) chk("b_stim", int'(stim_b), (r - 1) / 2);
      chk("b_busy", int'(busy_b), (r <= 17) ? 1 : 0);
    end
    wait_to(base + 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_stim", int'(stim_a), 0);
    chk("rst_first", int'(first_a), 0);
    chk("rst_b_busy", int'(busy_b), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    run_a(0, 0, 0, 1);
    run_a(1, 3, 0, 0);
    run_a(2, 1, 3, 0);

    // start pulses in cycles 5 and 21 must not restart; cycle 22 starts a new run.
    mode_a  = 1;
    base    = cyc;
    start_a = 1'b1;
    q_a.push_back('{base + 21, 3, 0, 0});
    for (int r = 1; r <= 23; r++) begin
      wait_to(base + r);
      start_a = 1'b0;
      if (r <= 22) chk("restart_busy", int'(busy_a), (r <= 21) ? 1 : 0);
      if (r == 5 || r == 21) start_a = 1'b1;
      if (r == 22) begin
        start_a = 1'b1;
        mode_a  = 0;
        q_a.push_back('{base + 22 + 21, 0, 0, 1});
      end
      if (r == 23) begin
        chk("restart_err_clr", int'(err_a), 0);
        chk("restart_busy2", int'(busy_a), 1);
      end
    end
    wait_to(base + 22 + 24);

    // Reset at cycle 12 discards the run; no done may follow.
    mode_a  = 1;
    base    = cyc;
    start_a = 1'b1;
    for (int r = 1; r <= 13; r++) begin
      wait_to(base + r);
      start_a = 1'b0;
      if (r == 12) begin
        chk("mid_err_before_rst", int'(err_a), 2);
        rst_a = 1'b1;
      end
      if (r == 13) begin
        rst_a = 1'b0;
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_stim", int'(stim_a), 0);
        chk("mid_rst_err", int'(err_a), 0);
        chk("mid_rst_pass", int'(pass_a), 0);
        chk("mid_rst_done", int'(done_a), 0);
      end
    end
    wait_to(base + 40);

    run_b(0, 0, 1);
    run_b(1, 8, 0);

    chk("a_pending_runs", q_a.size(), 0);
    chk("b_pending_runs", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
